switch_event_decoder: RTL and testbench

//   Input-side counterpart of the board LED drivers: takes the 4 raw push-button inputs,

---
 rtl/switch_event_decoder.sv | 141 ++++++++++++++
 tb/tb_switch_event_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_event_decoder.sv
// Four-channel push-button front end: 2-flop sync, debounce, then per-channel
// press / short / long / release classification with one-cycle event pulses.
module switch_event_decoder #(
  parameter int g_DEBOUNCE_LIMIT = 250000,
  parameter int g_LONG_LIMIT     = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Switch,
  output logic [3:0] o_Level,
  output logic [3:0] o_Press,
  output logic [3:0] o_Release,
  output logic [3:0] o_Short,
  output logic [3:0] o_Long
);

  localparam int DB_W   = $clog2(g_DEBOUNCE_LIMIT);
  localparam int HOLD_W = $clog2(g_LONG_LIMIT);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(g_DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(g_LONG_LIMIT - 1);

  // state    | meaning
  // IDLE     | debounced level low, waiting for a press
  // PRESSED  | level high, hold counter running toward the long threshold
  // HELD     | long event already reported, waiting for the release
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  logic [3:0]        sync1_q;
  logic [3:0]        sync2_q;
  logic [3:0]        level_q;
  logic [DB_W-1:0]   db_cnt_q [4];
  logic [3:0]        flip_d;
  logic [3:0]        rise_d;
  logic [3:0]        fall_d;

  state_t            state_q [4];
  logic [HOLD_W-1:0] hold_q  [4];
  logic [3:0]        press_q;
  logic [3:0]        release_q;
  logic [3:0]        short_q;
  logic [3:0]        long_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      flip_d[n] = (sync2_q[n] != level_q[n]) && (db_cnt_q[n] == DB_MAX);
    end
  end

  assign rise_d = flip_d & ~level_q;
  assign fall_d = flip_d & level_q;

  // Any cycle where the synced input agrees with the level restarts the count.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      level_q <= '0;
      for (int n = 0; n < 4; n++) begin
        db_cnt_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (sync2_q[n] == level_q[n]) begin
          db_cnt_q[n] <= '0;
        end else if (db_cnt_q[n] == DB_MAX) begin
          db_cnt_q[n] <= '0;
          level_q[n]  <= ~level_q[n];
        end else begin
          db_cnt_q[n] <= db_cnt_q[n] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      press_q   <= '0;
      release_q <= '0;
      short_q   <= '0;
      long_q    <= '0;
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= ST_IDLE;
        hold_q[n]  <= '0;
      end
    end else begin
      press_q   <= rise_d;
      release_q <= fall_d;
      short_q   <= '0;
      long_q    <= '0;
      for (int n = 0; n < 4; n++) begin
        case (state_q[n])
          ST_IDLE: begin
            if (rise_d[n]) begin
              state_q[n] <= ST_PRESSED;
              hold_q[n]  <= '0;
            end
          end
          ST_PRESSED: begin
            // A release on the threshold cycle is still reported as short.
            if (fall_d[n]) begin
              state_q[n] <= ST_IDLE;
              short_q[n] <= 1'b1;
            end else if (hold_q[n] == HOLD_MAX) begin
              state_q[n] <= ST_HELD;
              long_q[n]  <= 1'b1;
            end else begin
              hold_q[n] <= hold_q[n] + 1'b1;
            end
          end
          ST_HELD: begin
            if (fall_d[n]) begin
              state_q[n] <= ST_IDLE;
            end
          end
          default: begin
            state_q[n] <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_Level   = level_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Short   = short_q;
  assign o_Long    = long_q;

endmodule

// File: tb/tb_switch_event_decoder.sv
// Bench for switch_event_decoder: directed scenarios with literal expectations plus
// randomized button activity checked every cycle against a timestamp-based model.
module tb_switch_event_decoder;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [3:0] i_Switch = '0;
  logic [3:0] o_Level, o_Press, o_Release, o_Short, o_Long;

  switch_event_decoder #(
    .g_DEBOUNCE_LIMIT(DB),
    .g_LONG_LIMIT    (LONG)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Switch (i_Switch),
    .o_Level  (o_Level),
    .o_Press  (o_Press),
    .o_Release(o_Release),
    .o_Short  (o_Short),
    .o_Long   (o_Long)
  );

  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: raw samples history, level flips when the last DB values seen by the
  // debouncer (raw delayed two clocks) all differ; events from press timestamps.
  logic [3:0] hist [$];
  logic [3:0] m_level, m_press, m_release, m_short, m_long;
  int         press_at [4];
  bit         long_done [4];
  int         cyc;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 8; i++) hist.push_back(4'h0);
    m_level = '0; m_press = '0; m_release = '0; m_short = '0; m_long = '0;
    for (int n = 0; n < 4; n++) begin
      press_at[n]  = -1;
      long_done[n] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [3:0] flip;
    bit all_diff;
    cyc++;
    flip = '0;
    for (int n = 0; n < 4; n++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (hist[hist.size() - 2 - j][n] == m_level[n]) all_diff = 1'b0;
      end
      flip[n] = all_diff;
    end
    hist.push_back(i_Switch);
    void'(hist.pop_front());
    for (int n = 0; n < 4; n++) begin
      m_press[n]   = flip[n] & ~m_level[n];
      m_release[n] = flip[n] & m_level[n];
      m_short[n]   = flip[n] & m_level[n] & ~long_done[n];
      m_long[n]    = 1'b0;
      if (m_press[n]) begin
        press_at[n]  = cyc;
        long_done[n] = 1'b0;
      end else if (m_release[n]) begin
        press_at[n] = -1;
      end else if (m_level[n] && !long_done[n] && (cyc - press_at[n] == LONG)) begin
        m_long[n]    = 1'b1;
        long_done[n] = 1'b1;
      end
    end
    m_level = m_level ^ flip;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge i_Clk or posedge i_Rst);
      if (i_Rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge i_Clk);
      if (chk_en) begin
        total++;
        if ({o_Level, o_Press, o_Release, o_Short, o_Long} !==
            {m_level, m_press, m_release, m_short, m_long}) begin
          bad++;
          $display("FAIL model t=%0t lvl/prs/rel/sht/lng got %h/%h/%h/%h/%h expected %h/%h/%h/%h/%h",
                   $time, o_Level, o_Press, o_Release, o_Short, o_Long,
                   m_level, m_press, m_release, m_short, m_long);
        end
      end
    end
  end

  logic [3:0] acc_lvl, acc_press, acc_rel, acc_short, acc_long;
  int n_long2;

  task automatic clr();
    acc_lvl = '0; acc_press = '0; acc_rel = '0; acc_short = '0; acc_long = '0;
    n_long2 = 0;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge i_Clk);
      acc_lvl   |= o_Level;
      acc_press |= o_Press;
      acc_rel   |= o_Release;
      acc_short |= o_Short;
      acc_long  |= o_Long;
      if (o_Long[2]) n_long2++;
    end
  endtask

  task automatic check(string name, logic [19:0] got, logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  int seg_left [4];

  initial begin
    clr();
    step(3);
    check("reset_outputs", {o_Level, o_Press, o_Release, o_Short, o_Long}, 20'h0);
    i_Rst = 1'b0;
    chk_en = 1'b1;

    clr();
    step(100);
    check("idle_quiet", {16'h0, acc_lvl | acc_press | acc_rel | acc_short | acc_long}, 20'h0);

    // bit 0 press latency
    i_Switch[0] = 1'b1;
    step(5);
    check("b0_level_t5", {16'h0, o_Level}, 20'h0);
    step(1);
    check("b0_press_t6", {12'h0, o_Level, o_Press}, {12'h0, 4'b0001, 4'b0001});
    step(1);
    check("b0_press_t7", {12'h0, o_Level, o_Press}, {12'h0, 4'b0001, 4'b0000});
    i_Switch[0] = 1'b0;
    step(10);

    // bit 1 short press
    clr();
    i_Switch[1] = 1'b1;
    step(6);
    check("b1_press", {16'h0, o_Press}, 20'h2);
    step(10);
    i_Switch[1] = 1'b0;
    step(5);
    check("b1_rel_early", {16'h0, o_Release}, 20'h0);
    step(1);
    check("b1_rel_short", {12'h0, o_Release, o_Short}, {12'h0, 4'b0010, 4'b0010});
    step(1);
    check("b1_rel_one_cycle", {12'h0, o_Release, o_Short}, 20'h0);
    check("b1_no_long", {16'h0, acc_long}, 20'h0);

    // bit 2 long hold
    clr();
    i_Switch[2] = 1'b1;
    step(6);
    check("b2_press", {16'h0, o_Press}, 20'h4);
    step(19);
    check("b2_long_early", {16'h0, acc_long}, 20'h0);
    step(1);
    check("b2_long", {16'h0, o_Long}, 20'h4);
    step(15);
    check("b2_long_once", 20'(n_long2), 20'd1);
    i_Switch[2] = 1'b0;
    step(6);
    check("b2_release", {12'h0, o_Release, o_Short}, {12'h0, 4'b0100, 4'b0000});
    step(2);

    // bit 1: release lands on the long threshold cycle, fall wins
    clr();
    i_Switch[1] = 1'b1;
    step(6);
    step(14);
    i_Switch[1] = 1'b0;
    step(6);
    check("b1_fall_wins", {8'h0, o_Release, o_Short, o_Long}, {8'h0, 4'b0010, 4'b0010, 4'b0000});
    step(3);
    check("b1_fall_wins_nolong", {16'h0, acc_long}, 20'h0);

    // bit 1: release one cycle after the threshold
    i_Switch[1] = 1'b1;
    step(6);
    step(15);
    i_Switch[1] = 1'b0;
    step(5);
    check("b1_long_then_rel", {16'h0, o_Long}, 20'h2);
    step(1);
    check("b1_rel_after_long", {12'h0, o_Release, o_Short}, {12'h0, 4'b0010, 4'b0000});
    step(3);

    // bit 3 bounce rejection
    clr();
    repeat (10) begin
      i_Switch[3] = 1'b1;
      step(3);
      i_Switch[3] = 1'b0;
      step(1);
    end
    step(10);
    check("b3_bounce", {16'h0, acc_lvl | acc_press | acc_rel | acc_short | acc_long}, 20'h0);

    // reset mid-press on bit 0
    i_Switch[0] = 1'b1;
    step(6);
    check("b0_press_again", {16'h0, o_Press}, 20'h1);
    step(5);
    #2 i_Rst = 1'b1;
    #1 check("rst_async", {o_Level, o_Press, o_Release, o_Short, o_Long}, 20'h0);
    step(2);
    i_Rst = 1'b0;
    step(5);
    check("rst_rel_level_t5", {16'h0, o_Level}, 20'h0);
    step(1);
    check("rst_rel_press_t6", {12'h0, o_Level, o_Press}, {12'h0, 4'b0001, 4'b0001});
    i_Switch[0] = 1'b0;
    step(30);

    // all four together
    i_Switch = 4'hF;
    step(6);
    check("all_press", {12'h0, o_Level, o_Press}, {12'h0, 4'hF, 4'hF});
    step(25);
    i_Switch = 4'h0;
    step(10);

    // randomized activity
    for (int n = 0; n < 4; n++) seg_left[n] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 4; n++) begin
        if (seg_left[n] == 0) begin
          i_Switch[n] = ~i_Switch[n];
          seg_left[n] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                    : int'($urandom_range(4, 30));
        end else begin
          seg_left[n]--;
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 i_Rst = 1'b1;
        step(2);
        i_Rst = 1'b0;
      end
      step(1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
